ex_stage_mdu: RTL and testbench

Parametrised execute stage for the pipelined MIPS CPU. It replaces the fixed single-cycle EX stage. It keeps the ID/EX pipeline register, the two-source operand forwarding muxes, the branch-target adder and the single-cycle ALU path. It adds valid/stall/flush pipeline control and an iterative multiply/divide unit that holds the pipeline upstream of EX while a multi-cycle operation runs.

---
 rtl/ex_pkg.sv | 37 +++
 rtl/alu.sv | 38 +++
 rtl/mdu_iter.sv | 99 +++++++++
 rtl/ex_stage_mdu.sv | 152 +++++++++++++++
 tb/tb_ex_stage_mdu.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects, MDU states.
// Pure declarations; no timing or flow-control behaviour of its own.
package ex_pkg;

  // Shift ops move operand B by A[log2(XLEN)-1:0]; LUI moves B up by XLEN/2.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  localparam logic [3:0] ALU_REMU = 4'b1110;
  localparam logic [3:0] ALU_RSV  = 4'b1111;

  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [3:0] aluc);
    return (aluc == ALU_MUL) || (aluc == ALU_DIVU) || (aluc == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU for op codes 0000-1011; MDU and reserved codes give 0.
// Latency: combinational; no backpressure.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      aluc,
  output logic [XLEN-1:0] r
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = a[SW-1:0];

  always_comb begin
    r = '0;
    case (aluc)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $unsigned($signed(b) >>> sh);
      ALU_LUI:  r = b << (XLEN/2);
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider (MUL low half, DIVU, REMU).
// Latency: XLEN steps in RUN plus one DONE cycle (divide by zero skips RUN); abort returns to IDLE.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e state_q, state_d;
  logic [3:0]      op_q;
  logic [XLEN-1:0] x_q;    // MUL: shifting multiplicand; DIV: dividend shifting out, quotient in
  logic [XLEN-1:0] y_q;    // MUL: shifting multiplier;   DIV: divisor
  logic [XLEN-1:0] acc_q;  // MUL: product;               DIV: partial remainder
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            div_zero, take;

  assign div_zero = (op != ALU_MUL) && (b == '0);
  assign take     = (state_q == MDU_IDLE) && start && !abort;
  assign rem_sh   = {acc_q, x_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, y_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start) state_d = div_zero ? MDU_DONE : MDU_RUN;
      MDU_RUN:  if (cnt_q == '0) state_d = MDU_DONE;
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (abort) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (take) begin
      op_q  <= op;
      cnt_q <= CW'(XLEN-1);
      y_q   <= b;
      if (div_zero) begin
        x_q   <= '1;
        acc_q <= a;
      end else begin
        x_q   <= a;
        acc_q <= '0;
      end
    end else if (state_q == MDU_RUN) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q == ALU_MUL) begin
        if (y_q[0]) acc_q <= acc_q + x_q;
        x_q <= x_q << 1;
        y_q <= y_q >> 1;
      end else if (!rem_diff[XLEN]) begin
        acc_q <= rem_diff[XLEN-1:0];
        x_q   <= {x_q[XLEN-2:0], 1'b1};
      end else begin
        acc_q <= rem_sh[XLEN-1:0];
        x_q   <= {x_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      ALU_MUL:  result = acc_q;
      ALU_DIVU: result = x_q;
      ALU_REMU: result = acc_q;
      default:  result = '0;
    endcase
  end

  assign busy = (state_q == MDU_RUN);
  assign done = (state_q == MDU_DONE);

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU, branch target, iterative MUL/DIVU/REMU.
// Latency 1 cycle (ALU) or XLEN+2 (MDU); ex_stall holds ID/IF while an MDU op is pending, flush kills it.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_inA,
  input  logic [XLEN-1:0] id_inB,
  input  logic [XLEN-1:0] id_pc4,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            id_wmem,
  input  logic            id_aluimm,
  input  logic            id_branch,
  input  logic            id_regrt,
  input  logic [3:0]      id_aluc,
  input  logic [AW-1:0]   id_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic [1:0]      id_fwa,
  input  logic [1:0]      id_fwb,
  input  logic [XLEN-1:0] mem_aluR,
  input  logic [XLEN-1:0] wb_dest,
  output logic            ex_stall,
  output logic            ex_valid,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic            ex_wmem,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_aluR,
  output logic [XLEN-1:0] ex_inB,
  output logic [XLEN-1:0] ex_pc,
  output logic [AW-1:0]   ex_destR,
  output logic            ex_zero
);

  typedef struct packed {
    logic            valid;
    logic            wreg;
    logic            m2reg;
    logic            wmem;
    logic            aluimm;
    logic            branch;
    logic            regrt;
    logic [3:0]      aluc;
    logic [1:0]      fwa;
    logic [1:0]      fwb;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] ina;
    logic [XLEN-1:0] inb;
    logic [XLEN-1:0] pc4;
  } idex_t;

  idex_t           idex_d, idex_q;
  logic [XLEN-1:0] a_fw, b_fw, b_alu, alu_r, mdu_result;
  logic            md_op, mdu_busy, mdu_done;

  function automatic logic [XLEN-1:0] fw_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                             input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
    case (sel)
      FW_REG:  return rf;
      FW_MEM:  return mem;
      default: return wb;
    endcase
  endfunction

  always_comb begin
    idex_d = '0;
    if (id_valid) begin
      idex_d.valid  = 1'b1;
      idex_d.wreg   = id_wreg;
      idex_d.m2reg  = id_m2reg;
      idex_d.wmem   = id_wmem;
      idex_d.aluimm = id_aluimm;
      idex_d.branch = id_branch;
      idex_d.regrt  = id_regrt;
      idex_d.aluc   = id_aluc;
      idex_d.fwa    = id_fwa;
      idex_d.fwb    = id_fwb;
      idex_d.rt     = id_rt;
      idex_d.rd     = id_rd;
      idex_d.imm    = id_imm;
      idex_d.ina    = id_inA;
      idex_d.inb    = id_inB;
      idex_d.pc4    = id_pc4;
    end
  end

  // Flush wins over stall so an aborted MDU op never leaves a stale instruction behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         idex_q <= '0;
    else if (flush)     idex_q <= '0;
    else if (!ex_stall) idex_q <= idex_d;
  end

  assign a_fw  = fw_mux(idex_q.fwa, idex_q.ina, mem_aluR, wb_dest);
  assign b_fw  = fw_mux(idex_q.fwb, idex_q.inb, mem_aluR, wb_dest);
  assign b_alu = idex_q.aluimm ? idex_q.imm : b_fw;
  assign md_op = (MD_EN != 0) && idex_q.valid && is_mdu_op(idex_q.aluc);

  alu #(.XLEN(XLEN)) u_alu (
    .a    (a_fw),
    .b    (b_alu),
    .aluc (idex_q.aluc),
    .r    (alu_r)
  );

  generate
    if (MD_EN != 0) begin : g_mdu
      mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_op && !flush),
        .abort  (flush),
        .op     (idex_q.aluc),
        .a      (a_fw),
        .b      (b_fw),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
      );
    end else begin : g_no_mdu
      assign mdu_busy   = 1'b0;
      assign mdu_done   = 1'b0;
      assign mdu_result = '0;
    end
  endgenerate

  // Stalled while the MDU is waiting to start or iterating; released in its DONE cycle.
  assign ex_stall = md_op && !flush && (mdu_busy || !mdu_done);
  assign ex_valid = md_op ? mdu_done : idex_q.valid;
  assign ex_aluR  = md_op ? (mdu_done ? mdu_result : '0) : alu_r;
  assign ex_zero  = ex_valid && (ex_aluR == '0);

  assign ex_wreg   = idex_q.wreg   && ex_valid;
  assign ex_m2reg  = idex_q.m2reg  && ex_valid;
  assign ex_wmem   = idex_q.wmem   && ex_valid;
  assign ex_branch = idex_q.branch && ex_valid;
  assign ex_inB    = b_fw;
  assign ex_pc     = idex_q.pc4 + (idex_q.imm << 2);
  assign ex_destR  = idex_q.regrt ? idex_q.rt : idex_q.rd;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: vector table, hand-written multi-cycle sequences, random ops vs. arithmetic model.
module tb_ex_stage_mdu;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NV   = 17;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_imm = '0, id_inA = '0, id_inB = '0, id_pc4 = '0;
  logic            id_wreg = 1'b0, id_m2reg = 1'b0, id_wmem = 1'b0;
  logic            id_aluimm = 1'b0, id_branch = 1'b0, id_regrt = 1'b0;
  logic [3:0]      id_aluc = '0;
  logic [AW-1:0]   id_rt = '0, id_rd = '0;
  logic [1:0]      id_fwa = '0, id_fwb = '0;
  logic [XLEN-1:0] mem_aluR = '0, wb_dest = '0;

  logic            ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
  logic [XLEN-1:0] ex_aluR, ex_inB, ex_pc;
  logic [AW-1:0]   ex_destR;
  logic            z_stall, z_valid, z_wreg, z_m2reg, z_wmem, z_branch, z_zero;
  logic [XLEN-1:0] z_aluR, z_inB, z_pc;
  logic [AW-1:0]   z_destR;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_mdu #(.XLEN(XLEN), .AW(AW), .MD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB), .id_pc4(id_pc4),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
    .id_branch(id_branch), .id_regrt(id_regrt), .id_aluc(id_aluc), .id_rt(id_rt), .id_rd(id_rd),
    .id_fwa(id_fwa), .id_fwb(id_fwb), .mem_aluR(mem_aluR), .wb_dest(wb_dest),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_wmem(ex_wmem), .ex_branch(ex_branch), .ex_aluR(ex_aluR), .ex_inB(ex_inB),
    .ex_pc(ex_pc), .ex_destR(ex_destR), .ex_zero(ex_zero)
  );

  ex_stage_mdu #(.XLEN(XLEN), .AW(AW), .MD_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB), .id_pc4(id_pc4),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
    .id_branch(id_branch), .id_regrt(id_regrt), .id_aluc(id_aluc), .id_rt(id_rt), .id_rd(id_rd),
    .id_fwa(id_fwa), .id_fwb(id_fwb), .mem_aluR(mem_aluR), .wb_dest(wb_dest),
    .ex_stall(z_stall), .ex_valid(z_valid), .ex_wreg(z_wreg), .ex_m2reg(z_m2reg),
    .ex_wmem(z_wmem), .ex_branch(z_branch), .ex_aluR(z_aluR), .ex_inB(z_inB),
    .ex_pc(z_pc), .ex_destR(z_destR), .ex_zero(z_zero)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] ra, rb, imm;
    logic        aluimm;
    logic [1:0]  fwa, fwb;
    logic [31:0] memv, wbv, exp_r;
    int          exp_stall;
    logic [31:0] exp_inb;
  } vec_t;

  vec_t vt[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fw(input logic [1:0] sel, input logic [31:0] rf, mem, wb);
    if (sel == 2'b00) return rf;
    if (sel == 2'b01) return mem;
    return wb;
  endfunction

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, b);
    logic [4:0] s;
    s = a[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << s;
      4'd9:  return b >> s;
      4'd10: return $unsigned($signed(b) >>> s);
      4'd11: return b * 32'h0001_0000;
      4'd12: return a * b;
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] ra, rb, imm, input logic aluimm,
                       input logic [1:0] fwa, fwb, input logic [31:0] memv, wbv);
    id_valid = 1'b1; id_aluc = op; id_inA = ra; id_inB = rb; id_imm = imm;
    id_aluimm = aluimm; id_regrt = aluimm; id_fwa = fwa; id_fwb = fwb;
    mem_aluR = memv; wb_dest = wbv; id_wreg = 1'b1; id_m2reg = 1'b0; id_wmem = 1'b0;
    id_branch = 1'b0; id_rt = 5'd5; id_rd = 5'd9; id_pc4 = 32'h100;
  endtask

  // Called at a negedge; returns at the negedge where the op completes.
  task automatic run_op(input logic [3:0] op, input logic [31:0] ra, rb, imm, input logic aluimm,
                        input logic [1:0] fwa, fwb, input logic [31:0] memv, wbv, output int stalls);
    drive(op, ra, rb, imm, aluimm, fwa, fwb, memv, wbv);
    @(negedge clk);
    id_valid = 1'b0;
    stalls = 0;
    while (ex_stall && stalls < 100) begin
      stalls++;
      if (stalls >= 2) begin
        mem_aluR = $urandom;
        wb_dest  = $urandom;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int st, n, hits;
    logic [3:0]  op;
    logic [31:0] ra, rb, imm, memv, wbv, a_e, bf, b_e, exp;
    logic        ai;
    logic [1:0]  fa, fb;
    int          exp_st;

    vt[0]  = '{ALU_ADD,  32'd5,          32'd3,          32'd0,          1'b0, 2'b01, 2'b00, 32'd7,          32'd0,  32'd10,         0,  32'd3};
    vt[1]  = '{ALU_SUB,  32'd5,          32'd5,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd0,          0,  32'd5};
    vt[2]  = '{ALU_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'h00F0_1200,  0,  32'h0FF0_FF00};
    vt[3]  = '{ALU_OR,   32'h1200_0000,  32'h0000_DEAD,  32'd0,          1'b0, 2'b00, 2'b10, 32'd0,          32'h34, 32'h1200_0034,  0,  32'h34};
    vt[4]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd1,          0,  32'd1};
    vt[5]  = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd0,          0,  32'd1};
    vt[6]  = '{ALU_SRA,  32'd4,          32'h8000_0000,  32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'hF800_0000,  0,  32'h8000_0000};
    vt[7]  = '{ALU_ADD,  32'h10,         32'h55,         32'hFFFF_FFF0,  1'b1, 2'b00, 2'b00, 32'd0,          32'd0,  32'd0,          0,  32'h55};
    vt[8]  = '{ALU_LUI,  32'd0,          32'd0,          32'h0000_ABCD,  1'b1, 2'b00, 2'b00, 32'd0,          32'd0,  32'hABCD_0000,  0,  32'd0};
    vt[9]  = '{ALU_SLL,  32'd8,          32'hFF,         32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'h0000_FF00,  0,  32'hFF};
    vt[10] = '{ALU_RSV,  32'd3,          32'd4,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd0,          0,  32'd4};
    vt[11] = '{ALU_MUL,  32'd0,          32'd5,          32'd0,          1'b0, 2'b01, 2'b00, 32'h0001_0003,  32'd0,  32'h0005_000F,  33, 32'd0};
    vt[12] = '{ALU_MUL,  32'h1234,       32'd0,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd0,          33, 32'd0};
    vt[13] = '{ALU_DIVU, 32'd100,        32'd0,          32'd0,          1'b0, 2'b00, 2'b11, 32'd0,          32'd7,  32'd14,         33, 32'd0};
    vt[14] = '{ALU_REMU, 32'd100,        32'd0,          32'd0,          1'b0, 2'b00, 2'b11, 32'd0,          32'd7,  32'd2,          33, 32'd0};
    vt[15] = '{ALU_DIVU, 32'd9,          32'd0,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'hFFFF_FFFF,  1,  32'd0};
    vt[16] = '{ALU_REMU, 32'd9,          32'd0,          32'd0,          1'b0, 2'b00, 2'b00, 32'd0,          32'd0,  32'd9,          1,  32'd0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", ex_stall, 0);
    check("rst_valid", ex_valid, 0);
    check("rst_aluR", ex_aluR, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_zero", ex_zero, 0);
    check("rst_wreg", ex_wreg, 0);
    check("rst_inB", ex_inB, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].op, vt[i].ra, vt[i].rb, vt[i].imm, vt[i].aluimm, vt[i].fwa, vt[i].fwb,
             vt[i].memv, vt[i].wbv, st);
      check($sformatf("v%0d_res", i), ex_aluR, vt[i].exp_r);
      check($sformatf("v%0d_stalls", i), st, vt[i].exp_stall);
      check($sformatf("v%0d_valid", i), ex_valid, 1);
      check($sformatf("v%0d_zero", i), ex_zero, (vt[i].exp_r == 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_dest", i), ex_destR, vt[i].aluimm ? 32'd5 : 32'd9);
      check($sformatf("v%0d_wreg", i), ex_wreg, 1);
      if (vt[i].exp_stall == 0) begin
        check($sformatf("v%0d_inB", i), ex_inB, vt[i].exp_inb);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d_pulse", i), ex_valid, 0);
      end
    end

    // Flush in the 10th RUN cycle of a DIVU
    drive(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    n = 1;
    while (n < 11 && ex_stall) begin
      @(negedge clk);
      n++;
    end
    check("fl_running", ex_stall, 1);
    flush = 1'b1;
    #1;
    check("fl_stall_drop", ex_stall, 0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_valid", ex_valid, 0);
    check("fl_stall", ex_stall, 0);
    run_op(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, st);
    check("fl_add_res", ex_aluR, 5);
    check("fl_add_stalls", st, 0);
    check("fl_add_valid", ex_valid, 1);
    run_op(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, st);
    check("fl_div_res", ex_aluR, 333);
    check("fl_div_stalls", st, 33);

    // MD_EN=0 instance: MUL gives 0 in one cycle
    drive(ALU_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    check("md0_res", z_aluR, 0);
    check("md0_stall", z_stall, 0);
    check("md0_valid", z_valid, 1);
    check("md0_zero", z_zero, 1);
    n = 1;
    while (ex_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("md0_dut_res", ex_aluR, 12);
    check("md0_dut_occ", n, 34);
    @(negedge clk);

    // Randomised ops against the arithmetic model
    for (int k = 0; k < 60; k++) begin
      op   = 4'($urandom_range(0, 15));
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      imm  = $urandom;
      ai   = 1'($urandom_range(0, 1));
      fa   = 2'($urandom_range(0, 3));
      fb   = 2'($urandom_range(0, 3));
      memv = $urandom;
      wbv  = (fb != 2'b00 && $urandom_range(0, 1) == 0) ? rb : $urandom;
      a_e  = fw(fa, ra, memv, wbv);
      bf   = fw(fb, rb, memv, wbv);
      if (op >= 4'd12 && op <= 4'd14) begin
        exp    = ref_op(op, a_e, bf);
        exp_st = (op != 4'd12 && bf == 0) ? 1 : 33;
      end else begin
        b_e    = ai ? imm : bf;
        exp    = ref_op(op, a_e, b_e);
        exp_st = 0;
      end
      run_op(op, ra, rb, imm, ai, fa, fb, memv, wbv, st);
      check($sformatf("r%0d_op%0d_res", k, op), ex_aluR, exp);
      check($sformatf("r%0d_stalls", k), st, exp_st);
      check($sformatf("r%0d_valid", k), ex_valid, 1);
      check($sformatf("r%0d_zero", k), ex_zero, (exp == 0) ? 32'd1 : 32'd0);
      if (exp_st == 0) check($sformatf("r%0d_inB", k), ex_inB, bf);
    end

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    drive(ALU_MUL, 32'd7, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_running", ex_stall, 1);
    rst_n = 1'b0;
    #1;
    check("mr_stall", ex_stall, 0);
    check("mr_valid", ex_valid, 0);
    check("mr_aluR", ex_aluR, 0);
    check("mr_pc", ex_pc, 0);
    check("mr_zero", ex_zero, 0);
    check("mr_destR", ex_destR, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ex_valid || ex_stall) hits++;
    end
    check("mr_no_partial", hits, 0);

    // Branch target after reset
    drive(ALU_SUB, 32'd4, 32'd4, 32'hFFFF_FFFC, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    id_branch = 1'b1;
    id_wreg   = 1'b0;
    @(negedge clk);
    id_valid = 1'b0;
    check("beq_pc", ex_pc, 32'hF0);
    check("beq_branch", ex_branch, 1);
    check("beq_zero", ex_zero, 1);
    check("beq_wreg", ex_wreg, 0);
    @(negedge clk);
    check("beq_bubble_branch", ex_branch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
